// File: rtl/keccak_absorb.sv
// Keccak sponge front-end: absorbs 64-bit lanes into a 1600-bit state, hands full
// blocks to an external permutation core, and presents the squeezed digest.
module keccak_absorb #(
    parameter int RATE_LANES = 17,
    parameter int DIGEST_W   = 256
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [63:0]         in_lane,
    input  logic                in_last,
    output logic                perm_start,
    output logic [1599:0]       perm_state,
    input  logic                perm_done,
    input  logic [1599:0]       perm_result,
    output logic                digest_valid,
    output logic [DIGEST_W-1:0] digest,
    input  logic                digest_ready,
    output logic                err
);

    localparam int CNT_W = (RATE_LANES > 1) ? $clog2(RATE_LANES) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(RATE_LANES - 1);

    typedef enum logic [1:0] {
        ABSORB,
        PERMUTE,
        SQUEEZE
    } state_t;

    state_t           r_fsm;
    logic [1599:0]    r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_last;
    logic             r_err;
    logic             r_perm_start;

    logic             w_xfer;
    logic             w_final;
    logic [CNT_W+5:0] w_base;

    assign w_xfer  = in_valid && (r_fsm == ABSORB);
    assign w_final = w_xfer && (r_cnt == LAST_IDX);
    assign w_base  = {r_cnt, 6'd0};

    assign in_ready     = (r_fsm == ABSORB);
    assign digest_valid = (r_fsm == SQUEEZE);
    assign perm_start   = r_perm_start;
    assign perm_state   = r_state;
    assign digest       = r_state[DIGEST_W-1:0];
    assign err          = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm        <= ABSORB;
            r_state      <= '0;
            r_cnt        <= '0;
            r_last       <= 1'b0;
            r_err        <= 1'b0;
            r_perm_start <= 1'b0;
        end else begin
            r_perm_start <= 1'b0;
            case (r_fsm)
                ABSORB: begin
                    if (w_xfer) begin
                        r_state[w_base +: 64] <= r_state[w_base +: 64] ^ in_lane;
                        if (w_final) begin
                            r_cnt        <= '0;
                            r_last       <= in_last;
                            r_perm_start <= 1'b1;
                            r_fsm        <= PERMUTE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                            // in_last before the final rate lane is a protocol violation
                            if (in_last)
                                r_err <= 1'b1;
                        end
                    end
                end
                PERMUTE: begin
                    if (perm_done) begin
                        r_state <= perm_result;
                        r_fsm   <= r_last ? SQUEEZE : ABSORB;
                    end
                end
                SQUEEZE: begin
                    if (digest_ready) begin
                        r_state <= '0;
                        r_last  <= 1'b0;
                        r_fsm   <= ABSORB;
                    end
                end
                default: r_fsm <= ABSORB;
            endcase
        end
    end

endmodule

// File: tb/tb_keccak_absorb.sv
// Directed bench for keccak_absorb: lane absorption, permutation handshake,
// squeeze backpressure, in_last protocol error and asynchronous reset.
module tb_keccak_absorb;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [63:0]   in_lane;
    logic          in_last;
    logic          perm_start;
    logic [1599:0] perm_state;
    logic          perm_done;
    logic [1599:0] perm_result;
    logic          digest_valid;
    logic [255:0]  digest;
    logic          digest_ready;
    logic          err;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    logic [1599:0] exp_st;
    logic [1599:0] r_blk;
    logic [1599:0] x_blk;

    keccak_absorb #(.RATE_LANES(17), .DIGEST_W(256)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_lane(in_lane), .in_last(in_last),
        .perm_start(perm_start), .perm_state(perm_state),
        .perm_done(perm_done), .perm_result(perm_result),
        .digest_valid(digest_valid), .digest(digest), .digest_ready(digest_ready),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag, input logic [1599:0] exp);
        for (int i = 0; i < 25; i++)
            check($sformatf("%s_lane%0d", tag, i), 256'(perm_state[i*64 +: 64]), 256'(exp[i*64 +: 64]));
    endtask

    task automatic send(input logic [63:0] lane, input logic last);
        in_valid = 1'b1;
        in_lane  = lane;
        in_last  = last;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_lane  = '0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_lane = '0; in_last = 1'b0;
        perm_done = 1'b0; perm_result = '0; digest_ready = 1'b0;
        #2;
        check("rst_perm_start", 256'(perm_start), 256'(0));
        check("rst_digest_valid", 256'(digest_valid), 256'(0));
        check("rst_err", 256'(err), 256'(0));
        check_state("rst_state", '0);
        step(); step();
        rst_n = 1'b1;
        check("post_rst_in_ready", 256'(in_ready), 256'(1));

        // Single block, lanes k+1, last on lane 16
        for (int k = 0; k < 17; k++) begin
            send(64'(k + 1), k == 16);
            if (k < 16) begin
                check($sformatf("b1_ready_%0d", k), 256'(in_ready), 256'(1));
                check($sformatf("b1_pstart_%0d", k), 256'(perm_start), 256'(0));
            end
        end
        check("b1_perm_start", 256'(perm_start), 256'(1));
        check("b1_in_ready", 256'(in_ready), 256'(0));
        exp_st = '0;
        for (int k = 0; k < 17; k++) exp_st[k*64 +: 64] = 64'(k + 1);
        check_state("b1_state", exp_st);

        // Permutation finishes one cycle after start; last=1 leads to squeeze
        step();
        check("b1_pstart_drop", 256'(perm_start), 256'(0));
        check("b1_wait_ready", 256'(in_ready), 256'(0));
        perm_done = 1'b1; perm_result = '1;
        step();
        perm_done = 1'b0; perm_result = '0;
        check("sq_valid", 256'(digest_valid), 256'(1));
        check("sq_digest", digest, '1);
        check("sq_in_ready", 256'(in_ready), 256'(0));
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("sq_hold_valid_%0d", i), 256'(digest_valid), 256'(1));
            check($sformatf("sq_hold_digest_%0d", i), digest, '1);
        end
        digest_ready = 1'b1;
        step();
        digest_ready = 1'b0;
        check("sq_done_valid", 256'(digest_valid), 256'(0));
        check("sq_done_ready", 256'(in_ready), 256'(1));
        check_state("sq_cleared", '0);

        // Two-block message: first block not last
        for (int k = 0; k < 17; k++) send(64'h100 + 64'(k), 1'b0);
        check("b2a_perm_start", 256'(perm_start), 256'(1));
        for (int i = 0; i < 25; i++) r_blk[i*64 +: 64] = 64'h0F0F_0F0F_0000_0000 + 64'(i);
        step();
        perm_done = 1'b1; perm_result = r_blk;
        step();
        perm_done = 1'b0; perm_result = '0;
        check("b2a_back_ready", 256'(in_ready), 256'(1));
        check("b2a_no_digest", 256'(digest_valid), 256'(0));
        check_state("b2a_loaded", r_blk);

        // perm_done while absorbing must be ignored
        perm_done = 1'b1; perm_result = '1;
        step();
        perm_done = 1'b0; perm_result = '0;
        check("absorb_done_ignored_ready", 256'(in_ready), 256'(1));
        check_state("absorb_done_ignored", r_blk);

        for (int k = 0; k < 17; k++) send(64'h00FF_00FF_00FF_00FF, k == 16);
        check("b2b_perm_start", 256'(perm_start), 256'(1));
        exp_st = r_blk;
        for (int k = 0; k < 17; k++) exp_st[k*64 +: 64] = r_blk[k*64 +: 64] ^ 64'h00FF_00FF_00FF_00FF;
        check_state("b2b_xor", exp_st);

        // perm_done coincident with perm_start is accepted
        for (int i = 0; i < 25; i++) x_blk[i*64 +: 64] = {32'hDEAD_0000 + 32'(i), 32'h1234_5678};
        perm_done = 1'b1; perm_result = x_blk;
        step();
        perm_done = 1'b0; perm_result = '0;
        check("b2b_sq_valid", 256'(digest_valid), 256'(1));
        check("b2b_digest", digest, x_blk[255:0]);
        digest_ready = 1'b1;
        step();
        digest_ready = 1'b0;
        check("b2b_back_ready", 256'(in_ready), 256'(1));

        // Early in_last on lane 3: sticky error, block still absorbs 17 lanes
        for (int k = 0; k < 17; k++) begin
            send(64'h5000 + 64'(k), k == 3);
            if (k == 2) check("err_before", 256'(err), 256'(0));
            if (k == 3) check("err_set", 256'(err), 256'(1));
            if (k == 3) check("err_still_ready", 256'(in_ready), 256'(1));
        end
        check("err_perm_start", 256'(perm_start), 256'(1));
        exp_st = '0;
        for (int k = 0; k < 17; k++) exp_st[k*64 +: 64] = 64'h5000 + 64'(k);
        check_state("err_state", exp_st);
        for (int i = 0; i < 25; i++) r_blk[i*64 +: 64] = 64'h7777_0000_0000_0000 | 64'(i);
        perm_done = 1'b1; perm_result = r_blk;
        step();
        perm_done = 1'b0; perm_result = '0;
        check("err_to_absorb", 256'(in_ready), 256'(1));
        check("err_no_digest", 256'(digest_valid), 256'(0));
        check("err_sticky", 256'(err), 256'(1));
        check_state("err_loaded", r_blk);

        // Asynchronous reset mid-permutation
        for (int k = 0; k < 17; k++) send(64'h1, k == 16);
        check("ar_perm_start", 256'(perm_start), 256'(1));
        step();
        check("ar_in_permute", 256'(in_ready), 256'(0));
        rst_n = 1'b0;
        #1;
        check("ar_perm_start_rst", 256'(perm_start), 256'(0));
        check("ar_digest_valid_rst", 256'(digest_valid), 256'(0));
        check("ar_err_rst", 256'(err), 256'(0));
        check_state("ar_state_rst", '0);
        #1;
        rst_n = 1'b1;
        perm_done = 1'b1; perm_result = '1;
        step();
        perm_done = 1'b0; perm_result = '0;
        check("ar_done_ignored_valid", 256'(digest_valid), 256'(0));
        check("ar_done_ignored_ready", 256'(in_ready), 256'(1));
        check("ar_done_ignored_pstart", 256'(perm_start), 256'(0));
        check_state("ar_done_ignored", '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
